matmul_ctrl_regs: RTL and testbench

Parametrised APB control/status register block for the matrix-multiply accelerator; successor to the fixed 16-bit control register. It holds the operation configuration and tracks the engine through an IDLE/BUSY/DONE state machine. It issues a one-cycle start pulse, completes with a `done` handshake, and raises an interrupt. Writes that arrive while the engine is running are rejected with `pslverr_o` and counted.

---
 rtl/matmul_ctrl_regs.sv | 186 ++++++++++++++++++
 tb/tb_matmul_ctrl_regs.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_ctrl_regs.sv
// APB control/status register block for the matrix-multiply engine.
// Holds the operation configuration and sequences the engine through IDLE/BUSY/DONE.
module matmul_ctrl_regs #(
    parameter  int DATA_W   = 32,
    parameter  int ADDR_W   = 8,
    parameter  int DIM_W    = 2,
    parameter  int ERRCNT_W = 8,
    localparam int CTRL_W   = 10 + 3 * DIM_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [DATA_W-1:0] pwdata_i,
    output logic [DATA_W-1:0] prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    input  logic              done_i,
    output logic              start_o,
    output logic [CTRL_W-1:0] cfg_o,
    output logic              irq_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CTRL_W-1:0]   r_cfg;
    logic                r_irq_en;
    logic                r_err;
    logic [ERRCNT_W-1:0] r_errcnt;
    logic                r_start;
    logic                r_irq;
    logic                r_accept;
    logic                r_reject;
    logic [DATA_W-1:0]   r_prdata;
    logic                r_pslverr;

    logic [ADDR_W-3:0] w_word;
    logic              w_is_ctrl;
    logic              w_is_status;
    logic              w_is_irqen;
    logic              w_addr_ok;
    logic              w_setup;
    logic              w_access;
    logic              w_busy;
    logic              w_reject_now;
    logic              w_accept_now;
    logic              w_ctrl_wr;
    logic              w_stat_wr;
    logic              w_irqen_wr;
    logic              w_rej;
    logic              w_go;
    logic              w_err_clr;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused_bits;

    assign w_word      = paddr_i[ADDR_W-1:2];
    assign w_is_ctrl   = (w_word == (ADDR_W-2)'(0));
    assign w_is_status = (w_word == (ADDR_W-2)'(1));
    assign w_is_irqen  = (w_word == (ADDR_W-2)'(2));
    assign w_addr_ok   = w_is_ctrl | w_is_status | w_is_irqen;

    assign w_setup  = psel_i & ~penable_i;
    assign w_access = psel_i & penable_i;
    assign w_busy   = (r_state == S_BUSY);

    // Accept/reject is decided on the setup edge and carried to the access edge,
    // so a done_i landing in between cannot turn a rejected write into an accepted one.
    assign w_reject_now = w_setup & pwrite_i & w_is_ctrl & w_busy;
    assign w_accept_now = w_setup & pwrite_i & w_addr_ok & ~w_reject_now;

    assign w_ctrl_wr  = w_access & r_accept & w_is_ctrl;
    assign w_stat_wr  = w_access & r_accept & w_is_status;
    assign w_irqen_wr = w_access & r_accept & w_is_irqen;
    assign w_rej      = w_access & r_reject;
    assign w_go       = w_ctrl_wr & pwdata_i[0];
    assign w_err_clr  = w_stat_wr & pwdata_i[2];

    assign w_unused_bits = ^{paddr_i[1:0], pwdata_i};

    always_comb begin
        w_rdata = '0;
        if (w_is_ctrl) begin
            w_rdata[CTRL_W-1:0] = {r_cfg[CTRL_W-1:1], w_busy};
        end else if (w_is_status) begin
            w_rdata[0]             = w_busy;
            w_rdata[1]             = (r_state == S_DONE);
            w_rdata[2]             = r_err;
            w_rdata[8 +: ERRCNT_W] = r_errcnt;
        end else if (w_is_irqen) begin
            w_rdata[0] = r_irq_en;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_go) w_state_nxt = S_BUSY;
            // done_i wins over a coincident W1C of done
            S_BUSY: if (done_i) w_state_nxt = S_DONE;
            S_DONE: begin
                if (w_go) begin
                    w_state_nxt = S_BUSY;
                end else if (w_stat_wr && pwdata_i[1]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_accept  <= 1'b0;
            r_reject  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else if (w_setup) begin
            r_accept  <= w_accept_now;
            r_reject  <= w_reject_now;
            r_prdata  <= pwrite_i ? '0 : w_rdata;
            r_pslverr <= ~w_addr_ok | w_reject_now;
        end else begin
            r_accept  <= 1'b0;
            r_reject  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cfg    <= '0;
            r_irq_en <= 1'b0;
            r_err    <= 1'b0;
            r_errcnt <= '0;
            r_start  <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_start <= w_go;
            r_irq   <= (r_state == S_DONE) & r_irq_en;
            if (w_ctrl_wr) begin
                r_cfg <= pwdata_i[CTRL_W-1:0];
            end
            if (w_irqen_wr) begin
                r_irq_en <= pwdata_i[0];
            end
            // A reject on the same edge as an err-clear keeps err and restarts the count at 1
            if (w_rej) begin
                r_err <= 1'b1;
                if (w_err_clr) begin
                    r_errcnt <= ERRCNT_W'(1);
                end else if (r_errcnt != '1) begin
                    r_errcnt <= r_errcnt + 1'b1;
                end
            end else if (w_err_clr) begin
                r_err    <= 1'b0;
                r_errcnt <= '0;
            end
        end
    end

    assign prdata_o  = r_prdata;
    assign pslverr_o = r_pslverr;
    assign pready_o  = 1'b1;
    assign start_o   = r_start;
    assign cfg_o     = r_cfg;
    assign irq_o     = r_irq;

endmodule

// File: tb/tb_matmul_ctrl_regs.sv
// Scoreboard bench for matmul_ctrl_regs (DIM_W=4, ERRCNT_W=2 build).
// APB responses are queued by the stimulus and checked by a separate monitor.
module tb_matmul_ctrl_regs;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 8;
    localparam int DIM_W    = 4;
    localparam int ERRCNT_W = 2;
    localparam int CTRL_W   = 10 + 3 * DIM_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              psel = 1'b0;
    logic              penable = 1'b0;
    logic              pwrite = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic [DATA_W-1:0] pwdata = '0;
    logic              done = 1'b0;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    logic              start;
    logic [CTRL_W-1:0] cfg;
    logic              irq;

    int checks = 0;
    int failures = 0;

    logic [32:0] exp_q[$];
    string       name_q[$];

    matmul_ctrl_regs #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DIM_W   (DIM_W),
        .ERRCNT_W(ERRCNT_W)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .psel_i   (psel),
        .penable_i(penable),
        .pwrite_i (pwrite),
        .paddr_i  (paddr),
        .pwdata_i (pwdata),
        .prdata_o (prdata),
        .pready_o (pready),
        .pslverr_o(pslverr),
        .done_i   (done),
        .start_o  (start),
        .cfg_o    (cfg),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: the access phase is where the registered response is presented
    always @(negedge clk) begin
        if (rst_n && psel && penable) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL apb_unexpected actual=response required=none queued");
            end else begin
                logic [32:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                chk({n, "_prdata"}, prdata, e[32:1]);
                chk({n, "_pslverr"}, {31'd0, pslverr}, {31'd0, e[0]});
                chk({n, "_pready"}, {31'd0, pready}, 32'd1);
            end
        end
    end

    // done_at: 0 none, 1 pulse on the setup edge, 2 pulse on the access edge
    task automatic apb(input string name, input logic wr, input logic [7:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_rd,
                       input logic exp_err, input int done_at = 0);
        exp_q.push_back({exp_rd, exp_err});
        name_q.push_back(name);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        done = (done_at == 1);
        @(posedge clk); #1;
        penable = 1'b1;
        done = (done_at == 2);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; done = 1'b0;
    endtask

    task automatic rd(input string name, input logic [7:0] addr, input logic [31:0] exp_rd,
                      input logic exp_err);
        apb(name, 1'b0, addr, 32'h0, exp_rd, exp_err);
    endtask

    task automatic wr(input string name, input logic [7:0] addr, input logic [31:0] data,
                      input logic exp_err);
        apb(name, 1'b1, addr, data, 32'h0, exp_err);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1 done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        chk("rst_cfg", 32'(cfg), 32'h0);
        chk("rst_start", {31'd0, start}, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pslverr", {31'd0, pslverr}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        rd("status_init", 8'h04, 32'h0, 1'b0);

        // start from IDLE
        wr("ctrl_a5e5", 8'h00, 32'h0000_A5E5, 1'b0);
        chk("start_hi", {31'd0, start}, 32'h1);
        chk("cfg_a5e5", 32'(cfg), 32'h0000_A5E5);
        tick();
        chk("start_lo", {31'd0, start}, 32'h0);
        rd("status_busy", 8'h04, 32'h1, 1'b0);
        rd("ctrl_rd_busy", 8'h00, 32'h0000_A5E5, 1'b0);

        // rejected writes while busy
        for (int unsigned i = 0; i < 3; i++) wr("ctrl_rej", 8'h00, 32'h1234, 1'b1);
        chk("cfg_after_rej", 32'(cfg), 32'h0000_A5E5);
        rd("status_rej3", 8'h04, 32'h305, 1'b0);
        for (int unsigned i = 0; i < 5; i++) wr("ctrl_rej_sat", 8'h00, 32'h1234, 1'b1);
        rd("status_sat", 8'h04, 32'h305, 1'b0);
        wr("status_errclr", 8'h04, 32'h4, 1'b0);
        rd("status_cleared", 8'h04, 32'h1, 1'b0);

        // completion with interrupt
        wr("irqen_set", 8'h08, 32'h1, 1'b0);
        rd("irqen_rd", 8'h08, 32'h1, 1'b0);
        pulse_done();
        chk("irq_not_yet", {31'd0, irq}, 32'h0);
        tick();
        chk("irq_rise", {31'd0, irq}, 32'h1);
        rd("status_done", 8'h04, 32'h2, 1'b0);
        wr("status_w1c_done", 8'h04, 32'h2, 1'b0);
        chk("irq_hold", {31'd0, irq}, 32'h1);
        tick();
        chk("irq_fall", {31'd0, irq}, 32'h0);
        rd("status_idle", 8'h04, 32'h0, 1'b0);
        rd("ctrl_rd_idle", 8'h00, 32'h0000_A5E4, 1'b0);

        // field-only update and wide dimension fields
        wr("ctrl_fields", 8'h00, 32'hFFEA_BCDE, 1'b0);
        chk("start_none", {31'd0, start}, 32'h0);
        chk("cfg_fields", 32'(cfg), 32'h002A_BCDE);
        chk("dim_n", {28'd0, cfg[11:8]}, 32'hC);
        chk("dim_k", {28'd0, cfg[15:12]}, 32'hB);
        chk("dim_m", {28'd0, cfg[19:16]}, 32'hA);
        rd("ctrl_rd_fields", 8'h00, 32'h002A_BCDE, 1'b0);
        rd("status_still_idle", 8'h04, 32'h0, 1'b0);

        // done_i coincident with W1C of done: done stays set
        wr("ctrl_go2", 8'h00, 32'h1, 1'b0);
        chk("start_go2", {31'd0, start}, 32'h1);
        rd("status_busy2", 8'h04, 32'h1, 1'b0);
        apb("status_w1c_race", 1'b1, 8'h04, 32'h2, 32'h0, 1'b0, 2);
        rd("status_done_wins", 8'h04, 32'h2, 1'b0);
        chk("irq_race", {31'd0, irq}, 32'h1);

        // restart straight from DONE
        wr("ctrl_from_done", 8'h00, 32'h1, 1'b0);
        chk("start_from_done", {31'd0, start}, 32'h1);
        rd("status_restart", 8'h04, 32'h1, 1'b0);
        chk("irq_after_restart", {31'd0, irq}, 32'h0);

        // done_i on the setup edge of a rejected write: still rejected, state DONE
        apb("ctrl_rej_done", 1'b1, 8'h00, 32'h1234, 32'h0, 1'b1, 1);
        chk("cfg_rej_done", 32'(cfg), 32'h1);
        rd("status_rej_done", 8'h04, 32'h106, 1'b0);

        // address decode
        rd("bad_rd", 8'h0C, 32'h0, 1'b1);
        wr("bad_wr", 8'h10, 32'hFFFF, 1'b1);
        rd("alias_irqen", 8'h09, 32'h1, 1'b0);
        rd("alias_status", 8'h07, 32'h106, 1'b0);

        // reset mid-busy
        wr("status_clr_all", 8'h04, 32'h6, 1'b0);
        rd("status_clean", 8'h04, 32'h0, 1'b0);
        wr("ctrl_go3", 8'h00, 32'h1235, 1'b0);
        tick();
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("rst2_cfg", 32'(cfg), 32'h0);
        chk("rst2_start", {31'd0, start}, 32'h0);
        chk("rst2_irq", {31'd0, irq}, 32'h0);
        chk("rst2_prdata", prdata, 32'h0);
        chk("rst2_pslverr", {31'd0, pslverr}, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        rd("status_after_rst", 8'h04, 32'h0, 1'b0);
        rd("irqen_after_rst", 8'h08, 32'h0, 1'b0);
        rd("ctrl_after_rst", 8'h00, 32'h0, 1'b0);

        tick();
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
